// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 movement-packet assembler.
//   ps2_state_t    - packet-assembly state (which byte is expected next)
//   PS2_SYNC_BIT   - bit of the status byte that is always 1 in a valid byte 0
//   PS2_ERR_NONE   - receiver error code meaning "byte received cleanly"
//   PS2_PKT_BYTES  - bytes per stream-mode movement packet
//   sat_inc8       - 8-bit increment that sticks at 255
package ps2_pkg;

  typedef enum logic [1:0] {
    S_B0 = 2'd0,
    S_B1 = 2'd1,
    S_B2 = 2'd2
  } ps2_state_t;

  localparam int          PS2_SYNC_BIT  = 3;
  localparam logic [1:0]  PS2_ERR_NONE  = 2'b00;
  localparam int          PS2_PKT_BYTES = 3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ps2_timeout_timer.sv
// ps2_timeout_timer: inter-byte watchdog for the packet assembler.
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - a byte was accepted this cycle; restart from zero
//   run       - a packet is partly assembled; count idle cycles
//   expired   - one-cycle pulse in the cycle the count reaches
//               TIMEOUT_CYCLES-1, so the owner acts on the edge that is
//               exactly TIMEOUT_CYCLES edges after the last accepted byte
module ps2_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TIMEOUT_W      = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] count;

  // A byte arriving in the terminal cycle wins over the timeout.
  assign expired = run && !clear && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || !run || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + TIMEOUT_W'(1);
    end
  end

endmodule

// File: rtl/ps2_packet_assembler.sv
// ps2_packet_assembler: builds the 3-byte PS/2 stream-mode packet
// (status, dX, dY) from receiver byte strobes and publishes it atomically.
//   CLK, RESET       - clock, asynchronous active-high reset
//   ENABLE           - stream mode active; low drops any partial packet
//   BYTE_READY       - one-cycle strobe, BYTE_READ/BYTE_ERROR_CODE valid
//   BYTE_READ        - received byte
//   BYTE_ERROR_CODE  - 00 ok, anything else is a framing/parity error
//   MOUSE_STATUS/DX/DY - last complete packet
//   SEND_INTERRUPT   - one-cycle pulse with each new packet
//   PKT_COUNT        - good packets, wrapping
//   ERR_COUNT        - discarded bytes/packets, saturating
//
// state | meaning
// S_B0  | waiting for status byte (sync bit must be set)
// S_B1  | status held in shadow, waiting for dX
// S_B2  | status and dX held, waiting for dY to commit
module ps2_packet_assembler
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TIMEOUT_W      = 17
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       BYTE_READY,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic       SEND_INTERRUPT,
  output logic [7:0] PKT_COUNT,
  output logic [7:0] ERR_COUNT
);

  ps2_state_t state;
  logic [7:0] shadow [PS2_PKT_BYTES-1];
  logic       timer_clear;
  logic       timer_run;
  logic       timed_out;

  // Any strobe while enabled (good or bad) restarts the watchdog; the
  // watchdog only runs while a packet is partly assembled.
  assign timer_clear = ENABLE && BYTE_READY;
  assign timer_run   = ENABLE && (state != S_B0);

  ps2_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_W      (TIMEOUT_W)
  ) u_timeout (
    .clk     (CLK),
    .rst     (RESET),
    .clear   (timer_clear),
    .run     (timer_run),
    .expired (timed_out)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state          <= S_B0;
      shadow[0]      <= '0;
      shadow[1]      <= '0;
      MOUSE_STATUS   <= '0;
      MOUSE_DX       <= '0;
      MOUSE_DY       <= '0;
      SEND_INTERRUPT <= 1'b0;
      PKT_COUNT      <= '0;
      ERR_COUNT      <= '0;
    end else begin
      SEND_INTERRUPT <= 1'b0;
      if (!ENABLE) begin
        state <= S_B0;
      end else if (BYTE_READY) begin
        if (BYTE_ERROR_CODE != PS2_ERR_NONE) begin
          state     <= S_B0;
          ERR_COUNT <= sat_inc8(ERR_COUNT);
        end else begin
          case (state)
            S_B0: begin
              if (BYTE_READ[PS2_SYNC_BIT]) begin
                shadow[0] <= BYTE_READ;
                state     <= S_B1;
              end else begin
                ERR_COUNT <= sat_inc8(ERR_COUNT);
              end
            end
            S_B1: begin
              shadow[1] <= BYTE_READ;
              state     <= S_B2;
            end
            S_B2: begin
              // All three output bytes load together so readers never
              // see a mix of two packets.
              MOUSE_STATUS   <= shadow[0];
              MOUSE_DX       <= shadow[1];
              MOUSE_DY       <= BYTE_READ;
              SEND_INTERRUPT <= 1'b1;
              PKT_COUNT      <= PKT_COUNT + 8'd1;
              state          <= S_B0;
            end
            default: state <= S_B0;
          endcase
        end
      end else if (timed_out) begin
        state     <= S_B0;
        ERR_COUNT <= sat_inc8(ERR_COUNT);
      end
    end
  end

endmodule

// File: tb/tb_ps2_packet_assembler.sv
module tb_ps2_packet_assembler;

  localparam int T = 50;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       ENABLE = 1'b0;
  logic       BYTE_READY = 1'b0;
  logic [7:0] BYTE_READ = 8'h00;
  logic [1:0] BYTE_ERROR_CODE = 2'b00;
  logic [7:0] MOUSE_STATUS, MOUSE_DX, MOUSE_DY, PKT_COUNT, ERR_COUNT;
  logic       SEND_INTERRUPT;

  ps2_packet_assembler #(.TIMEOUT_CYCLES(T), .TIMEOUT_W(6)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .BYTE_READY(BYTE_READY),
    .BYTE_READ(BYTE_READ), .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
    .MOUSE_STATUS(MOUSE_STATUS), .MOUSE_DX(MOUSE_DX), .MOUSE_DY(MOUSE_DY),
    .SEND_INTERRUPT(SEND_INTERRUPT), .PKT_COUNT(PKT_COUNT), .ERR_COUNT(ERR_COUNT)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a list of the bytes of the packet being gathered,
  // plus the number of idle cycles since the last received byte.
  logic [7:0] pend [3];
  int         npend, idle;
  int         m_st, m_dx, m_dy, m_int, m_pkt, m_err;

  task automatic model_reset();
    npend = 0; idle = 0;
    m_st = 0; m_dx = 0; m_dy = 0; m_int = 0; m_pkt = 0; m_err = 0;
  endtask

  task automatic model_err();
    if (m_err < 255) m_err++;
  endtask

  task automatic model_step(input logic en, input logic rdy,
                            input logic [7:0] b, input logic [1:0] e);
    m_int = 0;
    if (!en) begin
      npend = 0; idle = 0;
    end else if (rdy) begin
      idle = 0;
      if (e != 2'b00) begin
        npend = 0; model_err();
      end else if (npend == 0 && b[3] == 1'b0) begin
        model_err();
      end else begin
        pend[npend] = b;
        npend++;
        if (npend == 3) begin
          m_st = pend[0]; m_dx = pend[1]; m_dy = pend[2];
          m_int = 1; m_pkt = (m_pkt + 1) % 256; npend = 0;
        end
      end
    end else if (npend > 0) begin
      idle++;
      if (idle == T) begin
        npend = 0; idle = 0; model_err();
      end
    end
  endtask

  task automatic model_cmp();
    chk("model_status", MOUSE_STATUS, m_st);
    chk("model_dx", MOUSE_DX, m_dx);
    chk("model_dy", MOUSE_DY, m_dy);
    chk("model_int", SEND_INTERRUPT, m_int);
    chk("model_pkt", PKT_COUNT, m_pkt);
    chk("model_err", ERR_COUNT, m_err);
  endtask

  task automatic step(input logic en, input logic rdy,
                      input logic [7:0] b, input logic [1:0] e);
    @(negedge CLK);
    ENABLE = en; BYTE_READY = rdy; BYTE_READ = b; BYTE_ERROR_CODE = e;
    @(posedge CLK);
    model_step(en, rdy, b, e);
    #1;
    model_cmp();
    if (SEND_INTERRUPT) pulses++;
    BYTE_READY = 1'b0;
  endtask

  task automatic idle_step();
    step(1'b1, 1'b0, 8'h00, 2'b00);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1; BYTE_READY = 1'b0; ENABLE = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic en, rdy; logic [7:0] b; logic [1:0] e;
    logic [7:0] st, dx, dy; logic intr; logic [7:0] pc, ec;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input logic en, input logic rdy, input logic [7:0] b,
                              input logic [1:0] e, input logic [7:0] st,
                              input logic [7:0] dx, input logic [7:0] dy,
                              input logic intr, input logic [7:0] pc, input logic [7:0] ec);
    vec_t v;
    v.en = en; v.rdy = rdy; v.b = b; v.e = e; v.st = st; v.dx = dx; v.dy = dy;
    v.intr = intr; v.pc = pc; v.ec = ec;
    return v;
  endfunction

  initial begin
    int p0;
    tbl[0]  = mk(1, 1, 8'h08, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    tbl[1]  = mk(1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    tbl[2]  = mk(1, 1, 8'h05, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    tbl[3]  = mk(1, 1, 8'hFB, 0, 8'h08, 8'h05, 8'hFB, 1, 1, 0);
    tbl[4]  = mk(1, 0, 8'h00, 0, 8'h08, 8'h05, 8'hFB, 0, 1, 0);
    tbl[5]  = mk(1, 1, 8'h00, 0, 8'h08, 8'h05, 8'hFB, 0, 1, 1);
    tbl[6]  = mk(1, 1, 8'h18, 0, 8'h08, 8'h05, 8'hFB, 0, 1, 1);
    tbl[7]  = mk(1, 1, 8'h10, 0, 8'h08, 8'h05, 8'hFB, 0, 1, 1);
    tbl[8]  = mk(1, 1, 8'h20, 0, 8'h18, 8'h10, 8'h20, 1, 2, 1);
    tbl[9]  = mk(1, 1, 8'h08, 0, 8'h18, 8'h10, 8'h20, 0, 2, 1);
    tbl[10] = mk(1, 1, 8'h01, 0, 8'h18, 8'h10, 8'h20, 0, 2, 1);
    tbl[11] = mk(1, 1, 8'h02, 1, 8'h18, 8'h10, 8'h20, 0, 2, 2);
    tbl[12] = mk(1, 1, 8'h0C, 0, 8'h18, 8'h10, 8'h20, 0, 2, 2);
    tbl[13] = mk(1, 1, 8'h04, 0, 8'h18, 8'h10, 8'h20, 0, 2, 2);
    tbl[14] = mk(0, 1, 8'h99, 1, 8'h18, 8'h10, 8'h20, 0, 2, 2);
    tbl[15] = mk(1, 1, 8'h04, 0, 8'h18, 8'h10, 8'h20, 0, 2, 3);
    tbl[16] = mk(1, 1, 8'h0C, 0, 8'h18, 8'h10, 8'h20, 0, 2, 3);
    tbl[17] = mk(1, 1, 8'h04, 0, 8'h18, 8'h10, 8'h20, 0, 2, 3);
    tbl[18] = mk(1, 1, 8'h04, 0, 8'h0C, 8'h04, 8'h04, 1, 3, 3);
    tbl[19] = mk(1, 0, 8'h00, 0, 8'h0C, 8'h04, 8'h04, 0, 3, 3);

    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_status", MOUSE_STATUS, 0);
    chk("reset_int", SEND_INTERRUPT, 0);
    chk("reset_pkt", PKT_COUNT, 0);
    chk("reset_err", ERR_COUNT, 0);
    do_reset();

    // Table-driven basic packets, sync discard, error byte, ENABLE drop.
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].en, tbl[i].rdy, tbl[i].b, tbl[i].e);
      chk($sformatf("tbl%0d_status", i), MOUSE_STATUS, tbl[i].st);
      chk($sformatf("tbl%0d_dx", i), MOUSE_DX, tbl[i].dx);
      chk($sformatf("tbl%0d_dy", i), MOUSE_DY, tbl[i].dy);
      chk($sformatf("tbl%0d_int", i), SEND_INTERRUPT, tbl[i].intr);
      chk($sformatf("tbl%0d_pkt", i), PKT_COUNT, tbl[i].pc);
      chk($sformatf("tbl%0d_err", i), ERR_COUNT, tbl[i].ec);
    end

    // Timeout fires exactly T edges after the last accepted byte.
    do_reset();
    step(1, 1, 8'h08, 0);
    step(1, 1, 8'h01, 0);
    repeat (T - 1) idle_step();
    chk("to_before", ERR_COUNT, 0);
    idle_step();
    chk("to_fire_err", ERR_COUNT, 1);
    chk("to_fire_int", SEND_INTERRUPT, 0);
    step(1, 1, 8'h09, 0);
    step(1, 1, 8'h02, 0);
    step(1, 1, 8'h03, 0);
    chk("to_next_status", MOUSE_STATUS, 8'h09);
    chk("to_next_dy", MOUSE_DY, 8'h03);
    chk("to_next_pkt", PKT_COUNT, 1);

    // Byte arriving on the timeout edge wins.
    step(1, 1, 8'h08, 0);
    repeat (T - 1) idle_step();
    step(1, 1, 8'h02, 0);
    chk("race_err", ERR_COUNT, 1);
    step(1, 1, 8'h03, 0);
    chk("race_status", MOUSE_STATUS, 8'h08);
    chk("race_dx", MOUSE_DX, 8'h02);
    chk("race_int", SEND_INTERRUPT, 1);
    chk("race_pkt", PKT_COUNT, 2);

    // Asynchronous reset mid-packet.
    step(1, 1, 8'h0A, 0);
    step(1, 1, 8'h11, 0);
    #2 RESET = 1'b1;
    #1;
    chk("areset_status", MOUSE_STATUS, 0);
    chk("areset_dx", MOUSE_DX, 0);
    chk("areset_int", SEND_INTERRUPT, 0);
    chk("areset_pkt", PKT_COUNT, 0);
    chk("areset_err", ERR_COUNT, 0);
    model_reset();
    #1 RESET = 1'b0;

    // 256 packets: PKT_COUNT wraps back to 0.
    p0 = pulses;
    for (int i = 0; i < 256; i++) begin
      step(1, 1, 8'h08 | 8'(i & 8'hF7), 0);
      step(1, 1, 8'(i), 0);
      step(1, 1, 8'(255 - i), 0);
    end
    chk("wrap_pulses", pulses - p0, 256);
    chk("wrap_pkt", PKT_COUNT, 0);
    chk("wrap_status", MOUSE_STATUS, 8'hFF);
    chk("wrap_dy", MOUSE_DY, 8'h00);

    // ERR_COUNT saturates.
    for (int i = 0; i < 260; i++) step(1, 1, 8'h00, 0);
    chk("sat_err", ERR_COUNT, 255);
    do_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic en, rdy;
      logic [7:0] b;
      logic [1:0] e;
      int rate;
      rate = ((i / 400) % 2 == 0) ? 40 : 2;
      en  = ($urandom_range(99) < 96);
      rdy = ($urandom_range(99) < rate);
      b   = 8'($urandom);
      if ($urandom_range(99) < 70) b[3] = 1'b1;
      e   = ($urandom_range(99) < 8) ? 2'($urandom_range(3, 1)) : 2'b00;
      step(en, rdy, b, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
